// File: rtl/ascii_class_enumerator.sv
// Streams every 7-bit ASCII code of a selected class in ascending order, then a NUL terminator beat.
// Define ASCII_ENUM_COUNT_EN to add an 8-bit count of accepted data beats.
module ascii_class_enumerator (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] class_sel,
  input  logic       abort,
  output logic [7:0] out_char,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic       error
`ifdef ASCII_ENUM_COUNT_EN
  ,
  output logic [7:0] count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_TERM} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [6:0]  r_cnt;
  logic [3:0]  r_class;
  logic        r_done;
  logic        r_error;

  logic        w_accept;
  logic        w_start_ok;
  logic        w_member;
  logic [15:0] w_hit;

  logic w_lower, w_upper, w_digit, w_hex, w_punct, w_sym;
  logic w_brack, w_brace, w_op, w_space, w_vowel, w_other, w_nul_lf;

  assign w_start_ok = start && (class_sel <= 4'd12);
  assign w_accept   = out_valid && out_ready;

  // Class membership of the code currently under test.
  always_comb begin
    w_lower  = (r_cnt >= 7'h61) && (r_cnt <= 7'h7A);
    w_upper  = (r_cnt >= 7'h41) && (r_cnt <= 7'h5A);
    w_digit  = (r_cnt >= 7'h30) && (r_cnt <= 7'h39);
    w_hex    = ((r_cnt >= 7'h41) && (r_cnt <= 7'h46)) || ((r_cnt >= 7'h61) && (r_cnt <= 7'h66));
    w_punct  = r_cnt inside {7'h2E, 7'h2C, 7'h3A, 7'h3B, 7'h21, 7'h3F, 7'h27, 7'h22};
    w_sym    = r_cnt inside {7'h23, 7'h24, 7'h25, 7'h26, 7'h40};
    w_brack  = r_cnt inside {7'h28, 7'h29, 7'h5B, 7'h5D};
    w_brace  = r_cnt inside {7'h7B, 7'h7D};
    w_op     = r_cnt inside {7'h2B, 7'h2D, 7'h2A, 7'h2F, 7'h5C, 7'h3D, 7'h3C, 7'h3E};
    w_space  = r_cnt inside {7'h20, 7'h09, 7'h0A, 7'h0D};
    w_vowel  = r_cnt inside {7'h61, 7'h65, 7'h69, 7'h6F, 7'h75, 7'h41, 7'h45, 7'h49, 7'h4F, 7'h55};
    w_other  = !(w_lower || w_upper || w_digit || w_hex || w_punct || w_sym ||
                 w_brack || w_brace || w_op || w_space);
    w_nul_lf = (r_cnt == 7'h00) || (r_cnt == 7'h0A);

    w_hit = {3'b000, w_nul_lf, w_other, w_vowel, w_space, w_op, w_brace, w_brack,
             w_sym, w_punct, w_hex, w_digit, w_upper, w_lower};
    w_member = w_hit[r_class];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_start_ok) w_state_next = S_SCAN;
      S_SCAN: begin
        if (w_member) begin
          w_state_next = S_EMIT;
        end else if (r_cnt == 7'h7F) begin
          w_state_next = S_TERM;
        end
      end
      S_EMIT: if (w_accept) w_state_next = (r_cnt == 7'h7F) ? S_TERM : S_SCAN;
      S_TERM: if (w_accept) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    // Abort overrides any same-cycle handshake.
    if (abort && (r_state != S_IDLE)) w_state_next = S_IDLE;
  end

  always_comb begin
    out_valid = (r_state == S_EMIT) || (r_state == S_TERM);
    out_last  = (r_state == S_TERM);
    out_char  = (r_state == S_EMIT) ? {1'b0, r_cnt} : 8'h00;
    busy      = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 7'h00;
      r_class <= 4'h0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_class <= class_sel;
            r_cnt   <= 7'h00;
          end else if (start) begin
            r_error <= 1'b1;
          end
        end
        S_SCAN: if (!abort && !w_member && (r_cnt != 7'h7F)) r_cnt <= r_cnt + 7'd1;
        S_EMIT: if (!abort && w_accept && (r_cnt != 7'h7F)) r_cnt <= r_cnt + 7'd1;
        S_TERM: if (!abort && w_accept) r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign done  = r_done;
  assign error = r_error;

`ifdef ASCII_ENUM_COUNT_EN
  logic [7:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 8'h00;
    end else if ((r_state == S_IDLE) && w_start_ok) begin
      r_count <= 8'h00;
    end else if ((r_state == S_EMIT) && w_accept && !abort) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign count = r_count;
`endif

endmodule
